// File: rtl/note_phase_gen.sv
// Key-select DDS phase source: syncs 8 piano keys, picks the lowest held key and steps a
// 24-bit phase accumulator once per DIV clocks. Optional harmonics: `define NOTE_PHASE_HARMONIC_EN.
module note_phase_gen #(
  parameter int CLK_HZ = 12_000_000,
  parameter int DIV    = 256,
  parameter int ACC_W  = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_n,
  output logic [7:0] phase,
  output logic       sample_stb,
  output logic       gate,
  output logic [7:0] phase_h2,
  output logic [7:0] phase_h3
);

  localparam int CNT_W = $clog2(DIV);

  // The tuning ROM holds constants for one sample rate only.
  if (CLK_HZ / DIV != 46875) begin : g_bad_rate
    $error("note_phase_gen: tuning ROM assumes fs = 46875 Hz");
  end

  logic [7:0]       key_meta_r;
  logic [7:0]       key_s;
  logic [2:0]       sel_s;
  logic             any_s;
  logic [2:0]       note_sel_r;
  logic             key_any_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;
  logic [ACC_W-1:0] tw_s;
  logic [ACC_W-1:0] acc_r;
  logic             gate_r;
  logic             stb_r;

  function automatic logic [ACC_W-1:0] tw_lookup(input logic [2:0] sel);
    logic [ACC_W-1:0] tw;
    case (sel)
      3'd0:    tw = ACC_W'(24'd93640);
      3'd1:    tw = ACC_W'(24'd105105);
      3'd2:    tw = ACC_W'(24'd117979);
      3'd3:    tw = ACC_W'(24'd124994);
      3'd4:    tw = ACC_W'(24'd140302);
      3'd5:    tw = ACC_W'(24'd157482);
      3'd6:    tw = ACC_W'(24'd176767);
      3'd7:    tw = ACC_W'(24'd187278);
      default: tw = ACC_W'(24'd0);
    endcase
    return tw;
  endfunction

  // Two-flop synchroniser, stored active-high so that the reset value means "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_r <= 8'h00;
      key_s      <= 8'h00;
    end else begin
      key_meta_r <= ~key_n;
      key_s      <= key_meta_r;
    end
  end

  // Priority encoder: lowest held key index wins.
  always_comb begin
    sel_s = 3'd0;
    any_s = 1'b1;
    casez (key_s)
      8'b???????1: sel_s = 3'd0;
      8'b??????10: sel_s = 3'd1;
      8'b?????100: sel_s = 3'd2;
      8'b????1000: sel_s = 3'd3;
      8'b???10000: sel_s = 3'd4;
      8'b??100000: sel_s = 3'd5;
      8'b?1000000: sel_s = 3'd6;
      8'b10000000: sel_s = 3'd7;
      default: begin
        sel_s = 3'd0;
        any_s = 1'b0;
      end
    endcase
  end

  // Registered note selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_sel_r <= 3'd0;
      key_any_r  <= 1'b0;
    end else begin
      note_sel_r <= sel_s;
      key_any_r  <= any_s;
    end
  end

  // Sample-rate divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick_s = (cnt_r == CNT_W'(DIV - 1));
  assign tw_s   = tw_lookup(note_sel_r);

  // Fundamental accumulator; carry out is dropped so the phase wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {ACC_W{1'b0}};
      gate_r <= 1'b0;
      stb_r  <= 1'b0;
    end else if (tick_s) begin
      stb_r <= 1'b1;
      if (key_any_r) begin
        acc_r  <= acc_r + tw_s;
        gate_r <= 1'b1;
      end else begin
        acc_r  <= {ACC_W{1'b0}};
        gate_r <= 1'b0;
      end
    end else begin
      stb_r <= 1'b0;
    end
  end

  assign phase      = acc_r[ACC_W-1 -: 8];
  assign gate       = gate_r;
  assign sample_stb = stb_r;

`ifdef NOTE_PHASE_HARMONIC_EN
  logic [ACC_W-1:0] tw2_s;
  logic [ACC_W-1:0] tw3_s;
  logic [ACC_W-1:0] acc2_r;
  logic [ACC_W-1:0] acc3_r;

  assign tw2_s = {tw_s[ACC_W-2:0], 1'b0};
  assign tw3_s = tw_s + tw2_s;

  // Harmonic accumulators track the fundamental tick for tick and clear with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc2_r <= {ACC_W{1'b0}};
      acc3_r <= {ACC_W{1'b0}};
    end else if (tick_s && key_any_r) begin
      acc2_r <= acc2_r + tw2_s;
      acc3_r <= acc3_r + tw3_s;
    end else if (tick_s) begin
      acc2_r <= {ACC_W{1'b0}};
      acc3_r <= {ACC_W{1'b0}};
    end else begin
      acc2_r <= acc2_r;
      acc3_r <= acc3_r;
    end
  end

  assign phase_h2 = acc2_r[ACC_W-1 -: 8];
  assign phase_h3 = acc3_r[ACC_W-1 -: 8];
`else
  assign phase_h2 = 8'h00;
  assign phase_h3 = 8'h00;
`endif

endmodule
